// File: rtl/mem_lsu.sv
// Memory-access stage: issues loads/stores to block-RAM or the MMIO port,
// aligns fixed-latency BRAM read data with its destination tag and presents
// the writeback-side load result used by execute-stage forwarding.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   exe_*                    execute-stage op (valid, load, store, addr, data, rd tag)
//   stall                    freeze upstream stages (MMIO access outstanding)
//   dmem_*                   BRAM port; read data returns MEM_LAT cycles after dmem_re
//   io_req_*, io_resp_*      MMIO request/response handshake
//   wb_memdata, wb_rd, wb_mre  load result, its tag, and its valid strobe
module mem_lsu #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned MEM_LAT  = 2,
    parameter logic [3:0]  MMIO_TAG = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              exe_mre,
    input  logic              exe_mwe,
    input  logic [31:0]       exe_addr,
    input  logic [31:0]       exe_wdata,
    input  logic [6:0]        exe_rd,
    output logic              stall,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_re,
    input  logic [31:0]       dmem_rdata,
    output logic              io_req_valid,
    output logic              io_req_we,
    output logic [31:0]       io_req_addr,
    output logic [31:0]       io_req_wdata,
    input  logic              io_req_ready,
    input  logic              io_resp_valid,
    input  logic [31:0]       io_resp_data,
    output logic [31:0]       wb_memdata,
    output logic [6:0]        wb_rd,
    output logic              wb_mre
);

    localparam int unsigned TAG_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               req_we_q, req_we_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [31:0]        req_wdata_q, req_wdata_d;
    logic [TAG_W-1:0]   req_rd_q, req_rd_d;
    logic [31:0]        resp_data_q, resp_data_d;

    logic [MEM_LAT-1:0] pv_q, pv_d;
    logic [TAG_W-1:0]   ptag_q [MEM_LAT];
    logic [TAG_W-1:0]   ptag_d [MEM_LAT];

    logic op_c, is_mmio_c, mmio_start_c, bram_acc_c, bram_load_c;
    logic busy_c, drain_ok_c, head_v_c, done_load_c;

    // Op decode; gated by rst so every output reads 0 while reset is held.
    assign op_c         = exe_valid & (exe_mre | exe_mwe) & ~rst;
    assign is_mmio_c    = (exe_addr[31:28] == MMIO_TAG);
    assign mmio_start_c = op_c & is_mmio_c & (state_q == S_IDLE);
    // BRAM ops may also issue in DONE; an MMIO op seen in DONE is the one
    // completing (upstream still holds it), so it is not started again.
    assign bram_acc_c   = op_c & ~is_mmio_c & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign bram_load_c  = bram_acc_c & ~exe_mwe;

    assign busy_c = (state_q != S_IDLE) && (state_q != S_DONE);
    assign stall  = busy_c | mmio_start_c;

    assign dmem_addr  = bram_acc_c ? exe_addr[ADDR_W+1:2] : '0;
    assign dmem_wdata = (bram_acc_c & exe_mwe) ? exe_wdata : '0;
    assign dmem_we    = bram_acc_c & exe_mwe;
    assign dmem_re    = bram_load_c;

    // Tag pipeline: shifts every cycle so in-flight loads always drain.
    always_comb begin
        pv_d = '0;
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            ptag_d[i] = '0;
        end
        pv_d[0]   = bram_load_c;
        ptag_d[0] = bram_load_c ? exe_rd : '0;
        for (int i = 1; i < int'(MEM_LAT); i++) begin
            pv_d[i]   = pv_q[i-1];
            ptag_d[i] = ptag_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                ptag_q[i] <= '0;
            end
        end else begin
            pv_q <= pv_d;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                ptag_q[i] <= ptag_d[i];
            end
        end
    end

    // Pipe is empty after this cycle's shift when only the head (or nothing)
    // is valid; the head writes back this cycle, so the MMIO result cannot collide.
    always_comb begin
        drain_ok_c = 1'b1;
        for (int i = 0; i + 1 < int'(MEM_LAT); i++) begin
            if (pv_q[i]) begin
                drain_ok_c = 1'b0;
            end
        end
    end

    // MMIO FSM next-state and request latching.
    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_rd_d    = req_rd_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (mmio_start_c) begin
                    req_we_d    = exe_mwe;
                    req_addr_d  = exe_addr;
                    req_wdata_d = exe_wdata;
                    req_rd_d    = exe_rd;
                    state_d     = drain_ok_c ? S_REQ : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_ok_c) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (io_req_ready) begin
                    state_d = req_we_q ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                if (io_resp_valid) begin
                    resp_data_d = io_resp_data;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_rd_q    <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_rd_q    <= req_rd_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign io_req_valid = (state_q == S_REQ);
    assign io_req_we    = io_req_valid & req_we_q;
    assign io_req_addr  = io_req_valid ? req_addr_q : '0;
    assign io_req_wdata = io_req_valid ? req_wdata_q : '0;

    // Writeback mux: BRAM pipe head and MMIO DONE are mutually exclusive.
    assign head_v_c    = pv_q[MEM_LAT-1];
    assign done_load_c = (state_q == S_DONE) & ~req_we_q;

    assign wb_mre     = head_v_c | done_load_c;
    assign wb_rd      = head_v_c ? ptag_q[MEM_LAT-1] : (done_load_c ? req_rd_q : '0);
    assign wb_memdata = head_v_c ? dmem_rdata : (done_load_c ? resp_data_q : '0);

endmodule
